serial_sub_n: RTL and testbench

Parametrised multi-cycle N-bit subtractor that computes a − b − bin one DIGIT-bit slice per clock, least-significant slice first, with a ripple borrow carried between cycles in a register. It generalises the single-bit full subtractor to arbitrary width with a valid/ready handshake on both sides. It sits in the arithmetic datapath wherever a wide subtract can trade latency for area.

---
 rtl/serial_sub_n.sv | 113 +++++++++++
 tb/tb_serial_sub_n.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_sub_n.sv
// serial_sub_n: computes diff = a - b - bin, one DIGIT-bit slice per clock, least-significant slice first.
// The borrow ripples between cycles through a register.
// Latency: NSLICE cycles from accept to out_valid. Throughput: one operation per NSLICE+2 cycles.
// Backpressure: in_ready is high only in IDLE, and in_valid is ignored otherwise.
//   The result is held in DONE until out_ready is seen.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, bin;
//   out_valid/out_ready with diff, bout; busy is high while slices are being computed.
// Optional: define SERIAL_SUB_SAT_EN to clamp diff to 0 when the final borrow is set.
module serial_sub_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [31:0]      base;
  logic [DIGIT-1:0] a_s, b_s, r;
  logic [DIGIT:0]   sub;
  logic             nb, last;

  // Slice arithmetic. The extra top bit of the DIGIT+1 wide subtract is the borrow out of this slice.
  always_comb begin
    base = 32'(cnt) * 32'(DIGIT);
    a_s  = a_q[base +: DIGIT];
    b_s  = b_q[base +: DIGIT];
    sub  = {1'b0, a_s} - {1'b0, b_s} - {{DIGIT{1'b0}}, borrow};
    r    = sub[DIGIT-1:0];
    nb   = sub[DIGIT];
    last = (cnt == CW'(NSLICE - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
  end

  // Datapath. Slices not yet computed keep stale contents until DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          diff[base +: DIGIT] <= r;
          borrow              <= nb;
          cnt                 <= cnt + CW'(1);
          if (last) begin
            bout <= nb;
`ifdef SERIAL_SUB_SAT_EN
            // Unsigned saturation: an underflowing result clamps to zero. This overrides the top slice written above.
            if (nb) diff <= '0;
`else
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_n.sv
// Directed bench for serial_sub_n with two instances: WIDTH=16/DIGIT=4 and WIDTH=8/DIGIT=1.
// Inputs are driven and outputs sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_serial_sub_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv16 = 1'b0, ir16, bin16 = 1'b0, ov16, or16 = 1'b0, bout16, busy16;
  logic [15:0] a16 = '0, b16 = '0, diff16;
  logic        iv8 = 1'b0, ir8, bin8 = 1'b0, ov8, or8 = 1'b0, bout8, busy8;
  logic [7:0]  a8 = '0, b8 = '0, diff8;

  serial_sub_n #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bin16),
    .out_valid(ov16), .out_ready(or16), .diff(diff16), .bout(bout16), .busy(busy16));

  serial_sub_n #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .diff(diff8), .bout(bout8), .busy(busy8));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one edge on the 16-bit instance, then count edges until out_valid.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic bi, output int n);
    @(negedge clk);
    check("in_ready_before_accept", 32'(ir16), 32'd1);
    iv16 = 1'b1; a16 = a; b16 = b; bin16 = bi;
    @(negedge clk);
    iv16 = 1'b0;
    check("busy_after_accept", 32'(busy16), 32'd1);
    n = 0;
    while (!ov16 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                       input logic [15:0] ed, input logic eb);
    int n;
    start16(a, b, bi, n);
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_diff"}, 32'(diff16), 32'(ed));
    check({tag, "_bout"}, 32'(bout16), 32'(eb));
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    check({tag, "_in_ready_after_xfer"}, 32'(ir16), 32'd1);
    check({tag, "_out_valid_after_xfer"}, 32'(ov16), 32'd0);
  endtask

  logic [15:0] sat_ffff;
  int          n;
  int          pulses;

  initial begin
`ifdef SERIAL_SUB_SAT_EN
    sat_ffff = 16'h0000;
`else
    sat_ffff = 16'hFFFF;
`endif
    // Reset state
    #12;
    check("rst_in_ready", 32'(ir16), 32'd1);
    check("rst_out_valid", 32'(ov16), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_diff", 32'(diff16), 32'd0);
    check("rst_bout", 32'(bout16), 32'd0);
    check("rst_diff8", 32'(diff8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function
    run16("plain",   16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0);
    run16("under",   16'h0000, 16'h0001, 1'b0, sat_ffff, 1'b1);
    run16("ripple",  16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
    run16("binonly", 16'h0005, 16'h0005, 1'b1, sat_ffff, 1'b1);
    run16("big",     16'hFFFF, 16'h0F0F, 1'b0, 16'hF0F0, 1'b0);

    // Backpressure: hold DONE while offering new operands
    start16(16'h1234, 16'h0034, 1'b0, n);
    check("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; bin16 = 1'b0;
      @(negedge clk);
      check("bp_diff", 32'(diff16), 32'h1200);
      check("bp_bout", 32'(bout16), 32'd0);
      check("bp_in_ready", 32'(ir16), 32'd0);
      check("bp_out_valid", 32'(ov16), 32'd1);
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    check("bp_in_ready_after", 32'(ir16), 32'd1);
    check("bp_busy_after", 32'(busy16), 32'd0);

    // Reset while slice 2 is in progress
    @(negedge clk);
    iv16 = 1'b1; a16 = 16'h0000; b16 = 16'h0001; bin16 = 1'b0;
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before_rst", 32'(busy16), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(ir16), 32'd1);
    check("mid_rst_out_valid", 32'(ov16), 32'd0);
    check("mid_rst_busy", 32'(busy16), 32'd0);
    check("mid_rst_diff", 32'(diff16), 32'd0);
    check("mid_rst_bout", 32'(bout16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov16) pulses++;
    end
    check("mid_rst_no_out_valid", 32'(pulses), 32'd0);
    check("mid_rst_in_ready_after", 32'(ir16), 32'd1);

    // 8-bit, one bit per cycle
    @(negedge clk);
    check("w8_in_ready", 32'(ir8), 32'd1);
    iv8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; bin8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("w8_latency", 32'(n), 32'd8);
    check("w8_diff", 32'(diff8), 32'h4B);
    check("w8_bout", 32'(bout8), 32'd0);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("w8_in_ready_after", 32'(ir8), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
